// File: rtl/mux_arb_pkg.sv
// Shared constants, state type and helpers for the
// round-robin select-mux arbiter.
package mux_arb_pkg;

    localparam int unsigned NREQ  = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] onehot(
        input logic [SEL_W-1:0] idx
    );
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational round-robin winner search starting
// one past the last owner and wrapping modulo 8.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] win,
    output logic             any
);

    // First requester after 'last' in circular order wins.
    always_comb begin
        logic [SEL_W-1:0] idx;
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = last + SEL_W'(i);
            if (!any && req[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the 8:1 select mux with a bounded
// ownership window; grant and select are registered.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [SEL_W-1:0] pos,
    output logic             busy,
    output logic [2:0]       hold_cnt
);

    if (MAX_HOLD > 7) begin : g_bad_hold
        $error("MAX_HOLD must not exceed 7");
    end

    localparam logic [2:0] MAXH = MAX_HOLD[2:0];

    state_t           state_q, state_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0] pos_q, pos_d;
    logic [2:0]       hold_q, hold_d;

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] win;
    logic             any;
    logic             can_hold;

    // While granted, the search starts after the current owner
    // so a release re-arbitrates on the same edge.
    assign ptr = (state_q == GRANT) ? pos_q : last_q;

    rr_pick u_pick (
        .req  (req),
        .last (ptr),
        .win  (win),
        .any  (any)
    );

    assign can_hold = req[pos_q] &&
                      ((MAX_HOLD == 0) || (hold_q < MAXH));

    // Next-state: grant, hold, hand over or fall idle.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    gnt_d   = onehot(win);
                    pos_d   = win;
                    hold_d  = 3'd1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (can_hold) begin
                    if (hold_q != 3'd7) hold_d = hold_q + 3'd1;
                end else begin
                    last_d = pos_q;
                    if (any) begin
                        gnt_d  = onehot(win);
                        pos_d  = win;
                        hold_d = 3'd1;
                    end else begin
                        gnt_d   = '0;
                        hold_d  = 3'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 3'd7;
            gnt_q   <= '0;
            pos_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            pos_q   <= pos_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt      = gnt_q;
    assign pos      = pos_q;
    assign busy     = |gnt_q;
    assign hold_cnt = hold_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed checks for mux_sel_arbiter: reset, rotation,
// hold window, sole-owner expiry, idle release, mid-grant reset.
module tb_mux_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] pos;
    logic       busy;
    logic [2:0] hold_cnt;

    int n_chk;
    int n_err;

    mux_sel_arbiter #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .pos      (pos),
        .busy     (busy),
        .hold_cnt (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, check gnt legality.
    task automatic step();
        @(posedge clk);
        #1;
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic chk_g(input string tag,
                         input logic [7:0] eg,
                         input logic [2:0] ep,
                         input logic       eb,
                         input logic [2:0] eh);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".pos"}, 32'(pos), 32'(ep));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".hold"}, 32'(hold_cnt), 32'(eh));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = 8'hFF;
        #1;
        step();
        step();
        chk_g("reset", 8'h00, 3'd0, 1'b0, 3'd0);

        rst_n = 1'b1;
        req   = 8'h01;
        step();
        chk_g("first", 8'h01, 3'd0, 1'b1, 3'd1);
        req = 8'h00;
        step();
        chk_g("idle0", 8'h00, 3'd0, 1'b0, 3'd0);

        // rotation 2 -> 5 -> 7 -> 2 with no bubble
        req = 8'b1010_0100;
        step();
        chk_g("rot2", 8'h04, 3'd2, 1'b1, 3'd1);
        req = 8'b1010_0000;
        step();
        chk_g("rot5", 8'h20, 3'd5, 1'b1, 3'd1);
        req = 8'b1000_0100;
        step();
        chk_g("rot7", 8'h80, 3'd7, 1'b1, 3'd1);
        req = 8'b0010_0100;
        step();
        chk_g("rot2b", 8'h04, 3'd2, 1'b1, 3'd1);
        req = 8'h00;
        step();
        chk_g("idle2", 8'h00, 3'd2, 1'b0, 3'd0);

        // hold window: last=2, so 3 first, then 0, then 3
        req = 8'h09;
        for (int k = 0; k < 9; k++) begin
            logic [2:0] ep;
            ep = ((k / 4) % 2 == 0) ? 3'd3 : 3'd0;
            step();
            chk_g("window", 8'(1 << ep), ep, 1'b1, 3'((k % 4) + 1));
        end

        // sole requester 4: window expiry re-grants itself
        req = 8'h10;
        for (int k = 0; k < 8; k++) begin
            step();
            chk_g("sole", 8'h10, 3'd4, 1'b1, 3'((k % 4) + 1));
        end

        // owner 6 then release to idle, pos holds
        req = 8'h40;
        step();
        chk_g("own6", 8'h40, 3'd6, 1'b1, 3'd1);
        req = 8'h00;
        step();
        chk_g("rel6", 8'h00, 3'd6, 1'b0, 3'd0);
        step();
        chk_g("idle6", 8'h00, 3'd6, 1'b0, 3'd0);
        req = 8'h80;
        step();
        chk_g("own7", 8'h80, 3'd7, 1'b1, 3'd1);

        // reset mid-grant
        req = 8'h08;
        step();
        chk_g("own3", 8'h08, 3'd3, 1'b1, 3'd1);
        step();
        chk_g("own3h", 8'h08, 3'd3, 1'b1, 3'd2);
        rst_n = 1'b0;
        step();
        chk_g("midrst", 8'h00, 3'd0, 1'b0, 3'd0);
        rst_n = 1'b1;
        req   = 8'h09;
        step();
        chk_g("postrst", 8'h01, 3'd0, 1'b1, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
